fpu_pipe_arbiter: RTL and testbench

- Shares one STAGES-deep pipelined FPU between N requesters.
- Round-robin arbitration issues at most one operation per cycle into the FPU and drives the FPU pipeline enable.
- A valid/tag tracker shifts in lockstep with the FPU pipeline and routes each result back to the requester that issued it.
- Output back-pressure stalls the whole pipeline. Sits between the FPU datapath and its client units.

---
 rtl/fpu_pipe_arbiter_if.sv | 28 ++
 rtl/fpu_pipe_arbiter.sv | 110 +++++++++++
 tb/tb_fpu_pipe_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pipe_arbiter_if.sv
// Requester-side bus of the FPU pipe arbiter: issue handshake plus the
// per-requester result handshake with the shared result bus.
interface fpu_pipe_arbiter_if #(
  parameter int N   = 2,
  parameter int W   = 32,
  parameter int OPW = 2
);
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_ready;
  logic [N-1:0][W-1:0]   req_op_a;
  logic [N-1:0][W-1:0]   req_op_b;
  logic [N-1:0][OPW-1:0] req_opcode;
  logic [N-1:0]          res_valid;
  logic [N-1:0]          res_ready;
  logic [W-1:0]          res_data;

  // client units
  modport master (
    output req_valid, req_op_a, req_op_b, req_opcode, res_ready,
    input  req_ready, res_valid, res_data
  );

  // arbiter
  modport slave (
    input  req_valid, req_op_a, req_op_b, req_opcode, res_ready,
    output req_ready, res_valid, res_data
  );
endinterface

// File: rtl/fpu_pipe_arbiter.sv
// Round-robin arbiter sharing one STAGES-deep FPU among N requesters.
// A valid/tag shift register runs in lockstep with the FPU stages and steers
// each result back to its issuer; a stalled head freezes the whole pipe.
module fpu_pipe_arbiter #(
  parameter int N      = 2,
  parameter int STAGES = 6,
  parameter int W      = 32,
  parameter int OPW    = 2,
  localparam int TW    = (N > 1) ? $clog2(N) : 1,
  localparam int CW    = $clog2(STAGES + 1)
)(
  input  logic             clk,
  input  logic             rst,
  fpu_pipe_arbiter_if.slave bus,
  output logic             fpu_en,
  output logic             fpu_in_valid,
  output logic [W-1:0]     fpu_op_a,
  output logic [W-1:0]     fpu_op_b,
  output logic [OPW-1:0]   fpu_opcode,
  input  logic [W-1:0]     fpu_result,
  output logic [CW-1:0]    inflight
);

  logic [STAGES-1:0]         vld_pipe;
  logic [STAGES-1:0][TW-1:0] tag_pipe;
  logic [TW-1:0]             ptr;

  logic          head_vld;
  logic [TW-1:0] head_tag;
  logic          head_ready;
  logic          advance;
  logic          grant_any;
  logic [TW-1:0] grant_idx;
  logic [N-1:0]  grant;

  assign head_vld = vld_pipe[STAGES-1];
  assign head_tag = tag_pipe[STAGES-1];

  // Result steering: only the requester whose tag sits at the head sees valid.
  for (genvar i = 0; i < N; i++) begin : g_res
    assign bus.res_valid[i] = head_vld && (head_tag == TW'(i));
  end
  assign bus.res_data = fpu_result;

  // Head drains iff its owner is ready; reset also forces the pipe idle so no
  // enable or grant leaks out while rst is low.
  assign head_ready = |(bus.res_valid & bus.res_ready);
  assign advance    = rst && (!head_vld || head_ready);
  assign fpu_en     = advance;

  // Round-robin search starting at ptr; nothing is granted during a stall.
  always_comb begin
    int j;
    j         = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!grant_any && advance && bus.req_valid[j]) begin
        grant_any = 1'b1;
        grant_idx = TW'(j);
      end
    end
  end

  assign grant         = grant_any ? (N'(1) << grant_idx) : '0;
  assign bus.req_ready = grant;
  assign fpu_in_valid  = grant_any;

  // Operand mux: granted requester's slices, zeros on a bubble.
  always_comb begin
    fpu_op_a   = '0;
    fpu_op_b   = '0;
    fpu_opcode = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        fpu_op_a   = bus.req_op_a[i];
        fpu_op_b   = bus.req_op_b[i];
        fpu_opcode = bus.req_opcode[i];
      end
    end
  end

  // Tracker, pointer and occupancy all move only on advancing edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
      ptr      <= '0;
      inflight <= '0;
    end else if (advance) begin
      for (int k = STAGES - 1; k > 0; k--) begin
        vld_pipe[k] <= vld_pipe[k-1];
        tag_pipe[k] <= tag_pipe[k-1];
      end
      vld_pipe[0] <= grant_any;
      tag_pipe[0] <= grant_idx;
      if (grant_any)
        ptr <= (grant_idx == TW'(N - 1)) ? '0 : TW'(grant_idx + 1'b1);
      // an advancing edge with a valid head always consumes it
      case ({grant_any, head_vld})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_pipe_arbiter.sv
// Bench for fpu_pipe_arbiter: a queue/age model checks the N=2 instance every
// cycle, directed literal checks pin the model, and an N=3 instance covers
// wrap-around grant order and dropped requests.
module tb_fpu_pipe_arbiter;
  localparam int S = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] fop(logic [31:0] a, logic [31:0] b, logic [1:0] op);
    return (a + b) ^ {4{6'b0, op}};
  endfunction

  // ---------------- N=2 instance with a stand-in FPU ----------------
  fpu_pipe_arbiter_if #(.N(2), .W(32), .OPW(2)) b2();
  logic        fen2, fiv2;
  logic [31:0] fa2, fb2, fres2;
  logic [1:0]  fop2;
  logic [2:0]  infl2;
  logic [31:0] fp [S];

  fpu_pipe_arbiter #(.N(2), .STAGES(S), .W(32), .OPW(2)) dut2 (
    .clk(clk), .rst(rst), .bus(b2.slave),
    .fpu_en(fen2), .fpu_in_valid(fiv2), .fpu_op_a(fa2), .fpu_op_b(fb2),
    .fpu_opcode(fop2), .fpu_result(fres2), .inflight(infl2)
  );

  always @(posedge clk) begin
    if (fen2) begin
      for (int k = S - 1; k > 0; k--) fp[k] <= fp[k-1];
      fp[0] <= fop(fa2, fb2, fop2);
    end
  end
  assign fres2 = fp[S-1];

  // ---------------- N=3 instance, constant FPU result ----------------
  fpu_pipe_arbiter_if #(.N(3), .W(32), .OPW(2)) b3();
  logic        fen3, fiv3;
  logic [31:0] fa3, fb3;
  logic [31:0] fres3 = 32'hA5A5_0000;
  logic [1:0]  fop3;
  logic [2:0]  infl3;

  fpu_pipe_arbiter #(.N(3), .STAGES(S), .W(32), .OPW(2)) dut3 (
    .clk(clk), .rst(rst), .bus(b3.slave),
    .fpu_en(fen3), .fpu_in_valid(fiv3), .fpu_op_a(fa3), .fpu_op_b(fb3),
    .fpu_opcode(fop3), .fpu_result(fres3), .inflight(infl3)
  );

  // ---------------- behavioural model + per-cycle compare ----------------
  typedef struct { int tag; logic [31:0] val; int age; } ent_t;
  ent_t q[$];
  int   mptr = 0;

  initial begin
    bit          hv, efen;
    int          g, j;
    logic [1:0]  erv, erdy, eop;
    logic [31:0] ea, eb;
    forever begin
      @(negedge clk); #2;
      hv   = rst && q.size() > 0 && q[0].age == S;
      erv  = hv ? (2'b01 << q[0].tag) : 2'b00;
      efen = rst && (!hv || b2.res_ready[q[0].tag]);
      g = -1;
      if (efen)
        for (int k = 0; k < 2; k++) begin
          j = (mptr + k) % 2;
          if (g < 0 && b2.req_valid[j]) g = j;
        end
      erdy = (g >= 0) ? (2'b01 << g) : 2'b00;
      ea   = (g >= 0) ? b2.req_op_a[g]   : 32'h0;
      eb   = (g >= 0) ? b2.req_op_b[g]   : 32'h0;
      eop  = (g >= 0) ? b2.req_opcode[g] : 2'b0;
      chk("m_req_ready", b2.req_ready, erdy);
      chk("m_res_valid", b2.res_valid, erv);
      chk("m_fpu_en", fen2, efen);
      chk("m_fpu_in_valid", fiv2, g >= 0);
      chk("m_op_a", fa2, ea);
      chk("m_op_b", fb2, eb);
      chk("m_opcode", fop2, eop);
      chk("m_inflight", infl2, rst ? q.size() : 0);
      if (hv) chk("m_res_data", b2.res_data, q[0].val);
      @(posedge clk);
      if (!rst) begin
        q.delete();
        mptr = 0;
      end else if (efen) begin
        if (hv) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (g >= 0) begin
          q.push_back('{g, fop(ea, eb, eop), 1});
          mptr = (g + 1) % 2;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic settle();
    @(negedge clk); #1;
  endtask

  logic [2:0] t6_vld [7]  = '{3'b010, 3'b111, 3'b111, 3'b111, 3'b111, 3'b110, 3'b011};
  logic [2:0] t6_rdy [7]  = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b010, 3'b001};

  // ---------------- directed stimulus ----------------
  initial begin
    logic [1:0] e;
    rst = 1'b0;
    b2.req_valid = 2'b11; b2.res_ready = 2'b11;
    b2.req_op_a = '0; b2.req_op_b = '0; b2.req_opcode = '0;
    b3.req_valid = '0; b3.res_ready = 3'b111;
    b3.req_op_a = '0; b3.req_op_b = '0; b3.req_opcode = '0;

    // reset state, with requests pending to prove nothing leaks
    settle();
    chk("rst_fpu_en", fen2, 0);
    chk("rst_req_ready", b2.req_ready, 0);
    chk("rst_in_valid", fiv2, 0);
    chk("rst_inflight", infl2, 0);
    chk("rst_res_valid", b2.res_valid, 0);
    tick();
    rst = 1'b1; b2.req_valid = 2'b00;
    tick();

    // 1: single op from requester 0
    b2.req_valid = 2'b01;
    b2.req_op_a[0] = 32'h3F80_0000; b2.req_op_b[0] = 32'h4000_0000; b2.req_opcode[0] = 2'd0;
    settle();
    chk("t1_req_ready", b2.req_ready, 2'b01);
    chk("t1_in_valid", fiv2, 1);
    chk("t1_op_a", fa2, 32'h3F80_0000);
    tick();
    b2.req_valid = 2'b00;
    for (int k = 1; k <= 6; k++) begin
      settle();
      chk("t1_inflight", infl2, 1);
      chk("t1_res_valid", b2.res_valid, (k == 6) ? 2'b01 : 2'b00);
      if (k == 6) chk("t1_res_data", b2.res_data, 32'h7F80_0000);
      tick();
    end
    settle();
    chk("t1_inflight_end", infl2, 0);
    chk("t1_res_valid_end", b2.res_valid, 0);
    tick();

    // 4: six back-to-back issues from requester 1 alone
    b2.req_valid = 2'b10;
    for (int k = 0; k < 6; k++) begin
      b2.req_op_a[1] = 32'h100 * k; b2.req_op_b[1] = 32'h7 + k; b2.req_opcode[1] = 2'(k);
      settle();
      chk("t4_req_ready", b2.req_ready, 2'b10);
      tick();
    end
    b2.req_valid = 2'b00;
    for (int k = 0; k < 7; k++) begin
      settle();
      chk("t4_res_valid", b2.res_valid, (k < 6) ? 2'b10 : 2'b00);
      tick();
    end

    // 2: both requesters for 8 cycles, alternating grants starting at 0
    for (int c = 0; c < 14; c++) begin
      if (c < 8) begin
        b2.req_valid = 2'b11;
        b2.req_op_a[0] = 32'(c); b2.req_op_a[1] = 32'(c + 100);
        b2.req_op_b[0] = 32'h1000; b2.req_op_b[1] = 32'h2000;
        b2.req_opcode[0] = 2'd1; b2.req_opcode[1] = 2'd2;
      end else b2.req_valid = 2'b00;
      settle();
      e = (c < 8) ? ((c % 2) ? 2'b10 : 2'b01) : 2'b00;
      chk("t2_req_ready", b2.req_ready, e);
      e = (c >= 6) ? (((c - 6) % 2) ? 2'b10 : 2'b01) : 2'b00;
      chk("t2_res_valid", b2.res_valid, e);
      tick();
    end
    settle();
    chk("t2_res_valid_end", b2.res_valid, 0);
    tick();

    // 3: fill pipe with head tag 1, stall on res_ready[1]=0
    b2.res_ready = 2'b01;
    b2.req_valid = 2'b10;
    b2.req_op_a[1] = 32'h1111_0000; b2.req_op_b[1] = 32'h0000_2222; b2.req_opcode[1] = 2'd1;
    b2.req_op_a[0] = 32'h55; b2.req_op_b[0] = 32'h66; b2.req_opcode[0] = 2'd2;
    settle();
    chk("t3_req_ready0", b2.req_ready, 2'b10);
    tick();
    b2.req_op_a[1] = 32'h2222_0000;
    b2.req_valid = 2'b11;
    for (int c = 1; c < 6; c++) begin
      settle();
      chk("t3_req_ready_fill", b2.req_ready, (c % 2) ? 2'b01 : 2'b10);
      tick();
    end
    for (int c = 6; c < 11; c++) begin
      settle();
      chk("t3_fpu_en_stall", fen2, 0);
      chk("t3_req_ready_stall", b2.req_ready, 2'b00);
      chk("t3_inflight_stall", infl2, 6);
      chk("t3_res_valid_stall", b2.res_valid, 2'b10);
      chk("t3_res_data_stall", b2.res_data, 32'h1010_2323);
      tick();
    end
    b2.res_ready = 2'b11;
    settle();
    chk("t3_fpu_en_resume", fen2, 1);
    chk("t3_req_ready_full", b2.req_ready, 2'b10);
    chk("t3_inflight_full", infl2, 6);
    tick();
    b2.req_valid = 2'b00;
    for (int c = 0; c < 7; c++) tick();
    settle();
    chk("t3_inflight_drained", infl2, 0);
    tick();

    // 5: four in flight, asynchronous reset mid-cycle
    b2.req_valid = 2'b01;
    for (int c = 0; c < 4; c++) tick();
    #1;
    chk("t5_inflight_pre", infl2, 4);
    chk("t5_in_valid_pre", fiv2, 1);
    #1 rst = 1'b0;
    #1;
    chk("t5_inflight_rst", infl2, 0);
    chk("t5_in_valid_rst", fiv2, 0);
    chk("t5_res_valid_rst", b2.res_valid, 0);
    chk("t5_fpu_en_rst", fen2, 0);
    tick();
    rst = 1'b1; b2.req_valid = 2'b00;
    for (int c = 0; c < 10; c++) begin
      settle();
      chk("t5_res_valid_post", b2.res_valid, 0);
      tick();
    end

    // 6: N=3, wrap order 2,0,1,2 and a dropped request leaves no entry
    for (int c = 0; c < 14; c++) begin
      b3.req_valid = (c < 7) ? t6_vld[c] : 3'b000;
      settle();
      chk("t6_req_ready", b3.req_ready, (c < 7) ? t6_rdy[c] : 3'b000);
      chk("t6_res_valid", b3.res_valid, (c >= 6 && c < 13) ? t6_rdy[c-6] : 3'b000);
      if (c == 6) begin
        chk("t6_res_data", b3.res_data, 32'hA5A5_0000);
        chk("t6_inflight_full", infl3, 6);
      end
      if (c == 7) chk("t6_inflight_swap", infl3, 6);
      if (c == 13) chk("t6_inflight_end", infl3, 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
